// File: rtl/maxpool_sequencer.sv
// 2x2 stride-2 max pooling over a raster pixel stream: horizontal pair maxima of even rows
// are parked in a half-width line buffer and merged with the odd-row pair to form each output.
//
// state | meaning
// IDLE  | waiting for start; counters cleared on start
// RUN   | accepting pixels, producing pooled values
// FLUSH | last pixel taken; waiting for the final result to drain
// DONE  | one-cycle completion pulse
module maxpool_sequencer #(
    parameter int DATA_W = 20,
    parameter int MAP_W  = 8,
    parameter int MAP_H  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int CW = $clog2(MAP_W);
    localparam int RW = $clog2(MAP_H);
    localparam int NB = MAP_W / 2;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] line_buf [NB];

    logic              accept;
    logic              lb_we;
    logic [IW-1:0]     lb_idx;
    logic [DATA_W-1:0] pair;
    logic [DATA_W-1:0] pooled;

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign lb_idx    = IW'(col_q >> 1);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        lb_we       = 1'b0;
        accept      = 1'b0;
        pair        = max2(hold_q, in_data);
        pooled      = max2(line_buf[lb_idx], pair);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                in_ready = !out_valid_q || out_ready;
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (!out_valid_q || out_ready) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        accept = in_valid && in_ready;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (accept) begin
            if (!col_q[0]) begin
                hold_d = in_data;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = pooled;
            end

            if (col_q == CW'(MAP_W - 1)) begin
                col_d = '0;
                if (row_q == RW'(MAP_H - 1)) begin
                    row_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Even rows fully rewrite every entry before odd rows read it, so no reset is needed.
    always_ff @(posedge clk) begin
        if (lb_we) line_buf[lb_idx] <= pair;
    end

endmodule

// File: tb/tb_maxpool_sequencer.sv
// Directed bench for maxpool_sequencer on a 4x4 map: pooled values, handshake timing,
// stall behaviour, start/reset robustness.
module tb_maxpool_sequencer;
    localparam int DW   = 20;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst, start, busy, done;
    logic [DW-1:0] in_data, out_data;
    logic          in_valid, in_ready, out_valid, out_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    maxpool_sequencer #(.DATA_W(DW), .MAP_W(W), .MAP_H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DW-1:0] outq[$];
    int            out_cyc[$];
    int            acc_cyc[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    logic          done_busy = 1'b0;
    int            viol = 0;
    logic [DW-1:0] pix [NPIX];

    always @(negedge clk) begin
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
        if (out_valid && !out_ready && in_valid && in_ready) viol++;
        if (out_valid && out_ready) begin
            outq.push_back(out_data);
            out_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"}, 32'(out_data), 0);
    endtask

    task automatic clear_log();
        outq.delete();
        out_cyc.delete();
        acc_cyc.delete();
        viol = 0;
    endtask

    task automatic do_start(input string tag);
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_start_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_start_busy"}, 32'(busy), 1);
    endtask

    task automatic run_frame(input string tag, input int gap_n, input bit toggle,
                             input int restart_at, input int abort_at);
        int idx, k, d0;
        bit acc, restarted;
        idx = 0; k = 0; restarted = 0; d0 = done_cnt;
        while (k < 1000 && done_cnt == d0) begin
            in_valid  = (idx < NPIX) && (k % gap_n == 0);
            in_data   = (idx < NPIX) ? pix[idx] : '0;
            out_ready = toggle ? (k % 2 == 0) : 1'b1;
            start     = !restarted && restart_at >= 0 && idx == restart_at;
            if (start) restarted = 1;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            k++;
            if (acc) idx++;
            if (abort_at >= 0 && idx == abort_at) return;
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_done_seen"}, 32'(done_cnt - d0), 1);
        chk({tag, "_done_busy"}, 32'(done_busy), 0);
        if (out_cyc.size() > 0)
            chk({tag, "_done_timing"}, 32'(done_cyc), 32'(out_cyc[out_cyc.size()-1] + 1));
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_single_done"}, 32'(done_cnt - d0), 1);
        chk({tag, "_no_accept_in_stall"}, 32'(viol), 0);
        chk({tag, "_n_accept"}, 32'(acc_cyc.size()), NPIX);
    endtask

    task automatic chk_outs(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                            input logic [DW-1:0] e2, input logic [DW-1:0] e3);
        logic [DW-1:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_n_out"}, 32'(outq.size()), 4);
        for (int i = 0; i < 4 && i < outq.size(); i++)
            chk($sformatf("%s_out%0d", tag, i), 32'(outq[i]), 32'(e[i]));
    endtask

    initial begin
        int lat_pix [4];
        lat_pix[0] = 5; lat_pix[1] = 7; lat_pix[2] = 13; lat_pix[3] = 15;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 20'd9;
        @(posedge clk); #1;
        chk_idle("idle_ignores_input");
        in_valid = 1'b0;

        // Frame 1: ascending, full throughput
        for (int i = 0; i < NPIX; i++) pix[i] = DW'(i);
        clear_log();
        do_start("f1");
        run_frame("f1", 1, 0, -1, -1);
        chk_outs("f1", 5, 7, 13, 15);
        for (int i = 0; i < 4 && i < out_cyc.size() && acc_cyc.size() == NPIX; i++)
            chk($sformatf("f1_latency%0d", i), 32'(out_cyc[i]), 32'(acc_cyc[lat_pix[i]] + 1));
        if (acc_cyc.size() == NPIX)
            chk("f1_input_cycles", 32'(acc_cyc[NPIX-1] - acc_cyc[0] + 1), NPIX);

        // Frame 2: same data, downstream toggling
        clear_log();
        do_start("f2");
        run_frame("f2", 1, 1, -1, -1);
        chk_outs("f2", 5, 7, 13, 15);

        // Frame 3: unsigned compare and ties
        pix[0]  = 20'hFFFFF; pix[1]  = 20'd0; pix[2]  = 20'd7; pix[3]  = 20'd7;
        pix[4]  = 20'd0;     pix[5]  = 20'd1; pix[6]  = 20'd7; pix[7]  = 20'd7;
        for (int i = 8; i < NPIX; i++) pix[i] = 20'd7;
        clear_log();
        do_start("f3");
        run_frame("f3", 1, 0, -1, -1);
        chk_outs("f3", 20'd1048575, 7, 7, 7);

        // Frame 4: descending with input valid every third cycle
        for (int i = 0; i < NPIX; i++) pix[i] = DW'(NPIX - 1 - i);
        clear_log();
        do_start("f4");
        run_frame("f4", 3, 0, -1, -1);
        chk_outs("f4", 15, 13, 7, 5);

        // Frame 5: start re-pulsed mid-frame
        for (int i = 0; i < NPIX; i++) pix[i] = DW'(i);
        clear_log();
        do_start("f5");
        run_frame("f5", 1, 0, 6, -1);
        chk_outs("f5", 5, 7, 13, 15);

        // Frame 6: reset after 6 accepted pixels, then a clean frame
        clear_log();
        do_start("f6a");
        run_frame("f6a", 1, 0, -1, 6);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        chk_idle("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("after_rst");
        chk("rst_discard", 32'(outq.size()), 0);
        clear_log();
        do_start("f6b");
        run_frame("f6b", 1, 0, -1, -1);
        chk_outs("f6b", 5, 7, 13, 15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/maxpool_sequencer.md
# maxpool_sequencer

Frame-level controller that sequences a registered two-input max comparator to perform 2×2, stride-2 max pooling over a raster-ordered feature-map stream. It accepts one pixel per cycle on a valid/ready input and reduces horizontal pairs. It holds even-row pair maxima in an internal line buffer of MAP_W/2 entries, then emits one pooled value per 2×2 window on a valid/ready output. It sits between the convolution output stream and the next layer's input buffer.

## Interface
- DATA_W, 20, pixel width; unsigned
- MAP_W, 8, feature-map width in pixels; even, ≥2
- MAP_H, 8, feature-map height in pixels; even, ≥2
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle frame start; honoured only in IDLE
- busy  out  1  high from the cycle after an accepted start until the cycle DONE is entered
- done  out  1  one-cycle pulse when the frame's last pooled value has been accepted
- in_data  in  DATA_W  input pixel, raster order
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  DATA_W  pooled maximum
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data

## Operation
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0. State=IDLE; col/row counters=0; hold register=0. The line buffer is not reset.
- States:
  - IDLE: start=1 → RUN; counters cleared.
  - RUN: in_ready = !out_valid || out_ready.
  - RUN → FLUSH on acceptance of pixel (row MAP_H-1, col MAP_W-1).
  - FLUSH: in_ready=0. When out_valid=0, or out_valid && out_ready → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Accept = in_valid && in_ready. Counters advance only on accept. col wraps MAP_W-1→0 and increments row.
- Even col: hold ← in_data.
- Odd col: pair = max(hold, in_data).
  - Even row: line_buf[col>>1] ← pair. No output.
  - Odd row: out_data ← max(line_buf[col>>1], pair); out_valid ← 1.
- Compare is unsigned `a > b ? a : b`. On a tie either operand is returned; the values are identical.
- out_valid clears on out_valid && out_ready unless a new result loads the same cycle. A simultaneous load and drain keeps out_valid=1 with the new data.
- start outside IDLE is ignored. in_valid outside RUN is ignored, since in_ready=0.
- rst mid-frame returns the block to IDLE with reset values. Any pending out_data is discarded. The next frame is correct because even rows rewrite every line-buffer entry before it is read.

## Timing
- Input throughput: 1 pixel/cycle while downstream keeps up.
- Latency: out_valid rises the cycle after the accept of an odd-row, odd-col pixel.
- Single output register. When out_valid=1 and out_ready=0, in_ready=0 and the pipeline stalls with no loss.
- in_ready rises the cycle after start is sampled in IDLE.
- done asserts exactly one cycle after the last output handshake. busy falls in the same cycle.
- Total outputs per frame: (MAP_W/2)·(MAP_H/2).
- Line buffer: MAP_W/2 × DATA_W. Read and write at the same index never collide within a row.

## Test plan
- MAP_W=MAP_H=4, pixels 0..15 raster, out_ready=1, in_valid=1 → outputs 5, 7, 13, 15 in order, each one cycle after its pixel accept. done pulses once; frame takes 16 input cycles.
- Same frame with out_ready toggling 1/0 every cycle → identical output sequence. No pixel accepted while out_valid && !out_ready. No duplicate or dropped outputs.
- Window {2^20-1, 0, 0, 1} and a window of all equal values 7 → outputs 1048575 and 7. This confirms unsigned compare and tie handling.
- Descending frame 15..0 with in_valid gaps (valid every third cycle) → outputs 15, 13, 7, 5. Counters hold during gaps.
- start pulsed again mid-frame → ignored; outputs unchanged; a single done.
- rst asserted after 6 accepted pixels, then new start with pixels 0..15 → all outputs at reset values during and after rst. Second frame yields 5, 7, 13, 15.
